// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO write-port bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in;
    logic                          fifo_full;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic                          fifo_we;
    logic [DATA_WIDTH-1:0]         fifo_wdata;
    logic [IDX_W-1:0]              src_id;
    logic                          busy;

    modport slave (
        input  req, wdata_in, fifo_full,
        output gnt, ack, fifo_we, fifo_wdata, src_id, busy
    );

    modport master (
        output req, wdata_in, fifo_full,
        input  gnt, ack, fifo_we, fifo_wdata, src_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the shared FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                clk,
    input  logic                rst,
    fifo_wr_arbiter_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               cand_vld;
    logic [IDX_W-1:0]   cand_idx;
    int                 scan_j;
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // First requester strictly after last_q, wrapping; last_q itself is scanned last.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        scan_j   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_j = (int'(last_q) + k) % NUM_REQ;
            if (!cand_vld && bus.req[scan_j]) begin
                cand_vld = 1'b1;
                cand_idx = IDX_W'(scan_j);
            end
        end
    end

    always_comb begin
        sel_vld = (state_q == BURST) ? 1'b1 : cand_vld;
        sel_idx = (state_q == BURST) ? owner_q : cand_idx;
        gnt     = '0;
        if (sel_vld && !rst) begin
            gnt[sel_idx] = 1'b1;
        end
    end

    assign ack            = gnt & bus.req & {NUM_REQ{~bus.fifo_full}};
    assign bus.gnt        = gnt;
    assign bus.ack        = ack;
    assign bus.fifo_we    = |ack;
    assign bus.fifo_wdata = bus.wdata_in[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.src_id     = rst ? '0 : sel_idx;
    assign bus.busy       = (state_q == BURST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cand_vld && !bus.fifo_full) begin
                    owner_d = cand_idx;
                    if (MAX_BURST == 1) begin
                        last_d = cand_idx;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (bus.req[owner_q]) begin
                    // A full FIFO freezes the count so the stalled word is not charged.
                    if (!bus.fifo_full) begin
                        if (int'(cnt_q) + 1 == MAX_BURST) begin
                            last_d  = owner_q;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end else begin
                    last_d  = owner_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and randomized bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int BOUND = (NR - 1) * MB + NR;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] wd [NR];
    assign bus.wdata_in = {wd[3], wd[2], wd[1], wd[0]};

    int total = 0;
    int bad   = 0;

    // reference model state for the random phase
    bit            ep_open;
    int            ep_owner;
    int            ep_words;
    int            rr_last;
    int            cand;
    int            wait_w [NR];
    logic [NR-1:0] preq;
    logic [NR-1:0] prev_ack;
    logic [NR-1:0] e_ack;
    logic [NR-1:0] e_gnt;
    logic          e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, ".gnt"},  bus.gnt,     '0);
        chk({tag, ".ack"},  bus.ack,     '0);
        chk({tag, ".we"},   bus.fifo_we, '0);
        chk({tag, ".busy"}, bus.busy,    '0);
        chk({tag, ".src"},  bus.src_id,  '0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        #1;
        chk_quiet("rst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic [NR-1:0] x_ack,
                       input logic [NR-1:0] x_gnt, input logic x_busy);
        int a;
        int g;
        @(negedge clk);
        chk({tag, ".ack"},  bus.ack,     x_ack);
        chk({tag, ".gnt"},  bus.gnt,     x_gnt);
        chk({tag, ".we"},   bus.fifo_we, |x_ack);
        chk({tag, ".busy"}, bus.busy,    x_busy);
        g = idx_of(x_gnt);
        if (g >= 0) chk({tag, ".src"}, bus.src_id, g);
        a = idx_of(x_ack);
        if (a >= 0) chk({tag, ".wdata"}, bus.fifo_wdata, wd[a]);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) wd[i] = DW'(8'hA0 + i);

        // 1: all request; 0 wins first, each owner bursts MB words
        do_reset();
        bus.req = 4'b1111;
        for (int g = 0; g <= NR; g++) begin
            for (int b = 0; b < MB; b++) begin
                cyc("t1", 4'b0001 << (g % NR), 4'b0001 << (g % NR), b != 0);
            end
        end

        // 2: producer 2 alone, drops after two words
        do_reset();
        wd[2]   = 8'h55;
        bus.req = 4'b0100;
        cyc("t2a", 4'b0100, 4'b0100, 1'b0);
        cyc("t2b", 4'b0100, 4'b0100, 1'b1);
        bus.req = 4'b0000;
        cyc("t2c", 4'b0000, 4'b0100, 1'b1);
        cyc("t2d", 4'b0000, 4'b0000, 1'b0);
        bus.req = 4'b1001;
        cyc("t2e", 4'b1000, 4'b1000, 1'b0);

        // 3: full stalls owner 1 mid-burst
        do_reset();
        wd[1]   = 8'h3C;
        bus.req = 4'b0010;
        cyc("t3a", 4'b0010, 4'b0010, 1'b0);
        cyc("t3b", 4'b0010, 4'b0010, 1'b1);
        bus.fifo_full = 1'b1;
        repeat (3) cyc("t3full", 4'b0000, 4'b0010, 1'b1);
        bus.fifo_full = 1'b0;
        cyc("t3c", 4'b0010, 4'b0010, 1'b1);
        cyc("t3d", 4'b0010, 4'b0010, 1'b1);
        cyc("t3e", 4'b0010, 4'b0010, 1'b0);

        // 4: full while idle, then first write to the rr winner
        do_reset();
        wd[0]         = DW'($urandom);
        wd[3]         = DW'($urandom);
        bus.req       = 4'b1001;
        bus.fifo_full = 1'b1;
        cyc("t4full", 4'b0000, 4'b0001, 1'b0);
        cyc("t4full", 4'b0000, 4'b0001, 1'b0);
        bus.fifo_full = 1'b0;
        cyc("t4w", 4'b0001, 4'b0001, 1'b0);

        // 5: reset in the middle of producer 2's burst
        do_reset();
        wd[2]   = 8'h77;
        bus.req = 4'b0100;
        cyc("t5a", 4'b0100, 4'b0100, 1'b0);
        cyc("t5b", 4'b0100, 4'b0100, 1'b1);
        rst = 1'b1;
        #1;
        chk_quiet("t5rst");
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("t5c", 4'b0100, 4'b0100, 1'b0);
        repeat (MB - 1) cyc("t5d", 4'b0100, 4'b0100, 1'b1);
        cyc("t5e", 4'b0100, 4'b0100, 1'b0);

        // 6: random producers and full against the reference model
        do_reset();
        ep_open  = 1'b0;
        ep_owner = 0;
        ep_words = 0;
        rr_last  = NR - 1;
        preq     = '0;
        prev_ack = '0;
        for (int i = 0; i < NR; i++) wait_w[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (prev_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) preq[i] = 1'b0;
                    else wd[i] = DW'($urandom);
                end else if (!preq[i] && $urandom_range(0, 2) == 0) begin
                    preq[i] = 1'b1;
                    wd[i]   = DW'($urandom);
                end
            end
            bus.req       = preq;
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            @(negedge clk);

            e_ack  = '0;
            e_gnt  = '0;
            e_busy = ep_open;
            if (ep_open) begin
                e_gnt[ep_owner] = 1'b1;
                if (preq[ep_owner] && !bus.fifo_full) begin
                    e_ack[ep_owner] = 1'b1;
                    ep_words++;
                    if (ep_words == MB) begin
                        ep_open = 1'b0;
                        rr_last = ep_owner;
                    end
                end else if (!preq[ep_owner]) begin
                    ep_open = 1'b0;
                    rr_last = ep_owner;
                end
            end else begin
                cand = -1;
                for (int k = 1; k <= NR; k++) begin
                    if (cand < 0 && preq[(rr_last + k) % NR]) cand = (rr_last + k) % NR;
                end
                if (cand >= 0) begin
                    e_gnt[cand] = 1'b1;
                    if (!bus.fifo_full) begin
                        e_ack[cand] = 1'b1;
                        if (MB == 1) begin
                            rr_last = cand;
                        end else begin
                            ep_open  = 1'b1;
                            ep_owner = cand;
                            ep_words = 1;
                        end
                    end
                end
            end

            chk("t6.ack",  bus.ack,     e_ack);
            chk("t6.gnt",  bus.gnt,     e_gnt);
            chk("t6.we",   bus.fifo_we, |e_ack);
            chk("t6.busy", bus.busy,    e_busy);
            chk("t6.nowr_full", bus.fifo_we & bus.fifo_full, 1'b0);
            if (idx_of(e_gnt) >= 0) chk("t6.src", bus.src_id, idx_of(e_gnt));
            if (idx_of(e_ack) >= 0) chk("t6.wdata", bus.fifo_wdata, wd[idx_of(e_ack)]);

            for (int j = 0; j < NR; j++) begin
                if (!preq[j] || e_ack[j]) begin
                    wait_w[j] = 0;
                end else if (e_ack != '0) begin
                    wait_w[j]++;
                    chk("t6.starve", wait_w[j] <= BOUND, 1'b1);
                end
            end
            prev_ack = e_ack;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
